// File: rtl/pd3_defs.sv
// Shared pd3 pipeline definitions: datapath widths and the register-file write-data select encoding.
package pd3_defs;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    WDATA_SEL_WORD = 2'b00,
    WDATA_SEL_BYTE = 2'b01,
    WDATA_SEL_UIMM = 2'b10,
    WDATA_SEL_ALU  = 2'b11
  } wdata_sel_e;

  function automatic logic [31:0] upper_imm(input logic [15:0] imm);
    return {imm, 16'h0000};
  endfunction

endpackage

// File: rtl/load_byte_extract.sv
// Selects one byte of a big-endian memory word and sign- or zero-extends it.
module load_byte_extract
  import pd3_defs::*;
#(
  parameter int DATA_W = pd3_defs::DATA_W
) (
  input  logic [31:0]       i_word,
  input  logic [1:0]        i_off,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);

  logic [7:0] w_byte;

  // Offset 0 addresses the most significant byte.
  always_comb begin
    w_byte = 8'h00;
    case (i_off)
      2'd0:    w_byte = i_word[31:24];
      2'd1:    w_byte = i_word[23:16];
      2'd2:    w_byte = i_word[15:8];
      2'd3:    w_byte = i_word[7:0];
      default: w_byte = 8'h00;
    endcase
    if (i_unsigned) begin
      o_data = {{(DATA_W-8){1'b0}}, w_byte};
    end else begin
      o_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
    end
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and register-file write path of the pd3 pipeline,
// with WB-to-EX forwarding and a retired-instruction counter.
module mem_wb_writeback
  import pd3_defs::*;
#(
  parameter int DATA_W = pd3_defs::DATA_W,
  parameter int REG_AW = pd3_defs::REG_AW,
  parameter int CNT_W  = pd3_defs::CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic              in_stall,
  input  logic              in_flush,
  input  logic              in_reg_write,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_wdata_sel,
  input  logic              in_byte_unsigned,
  input  logic [1:0]        in_byte_off,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  input  logic [15:0]       in_imm,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_count
);

  logic              r_valid;
  logic              r_reg_write;
  logic [REG_AW-1:0] r_rd;
  wdata_sel_e        r_sel;
  logic              r_byte_unsigned;
  logic [1:0]        r_byte_off;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_mdata;
  logic [15:0]       r_imm;
  logic              r_done;
  logic [CNT_W-1:0]  r_retire_count;

  logic              w_retire;
  logic              w_fwd_valid;
  logic [DATA_W-1:0] w_byte_data;
  logic [DATA_W-1:0] w_wdata;

  // A stalled instruction retires on its first stall edge and is then marked done.
  assign w_retire    = r_valid & ~r_done & (in_stall | ~in_flush);
  assign w_fwd_valid = r_valid & r_reg_write & (r_rd != {REG_AW{1'b0}});

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_valid         <= 1'b0;
      r_reg_write     <= 1'b0;
      r_rd            <= {REG_AW{1'b0}};
      r_sel           <= WDATA_SEL_WORD;
      r_byte_unsigned <= 1'b0;
      r_byte_off      <= 2'b00;
      r_alu           <= {DATA_W{1'b0}};
      r_mdata         <= {DATA_W{1'b0}};
      r_imm           <= 16'h0000;
      r_done          <= 1'b0;
      r_retire_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_retire) begin
        r_retire_count <= r_retire_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (in_flush) begin
        r_valid <= 1'b0;
      end else if (in_stall) begin
        r_done <= r_done | r_valid;
      end else begin
        r_valid         <= in_valid;
        r_reg_write     <= in_reg_write;
        r_rd            <= in_rd;
        r_sel           <= wdata_sel_e'(in_wdata_sel);
        r_byte_unsigned <= in_byte_unsigned;
        r_byte_off      <= in_byte_off;
        r_alu           <= in_alu_result;
        r_mdata         <= in_mem_rdata;
        r_imm           <= in_imm;
        r_done          <= 1'b0;
      end
    end
  end

  load_byte_extract #(.DATA_W(DATA_W)) u_byte (
    .i_word     (r_mdata[31:0]),
    .i_off      (r_byte_off),
    .i_unsigned (r_byte_unsigned),
    .o_data     (w_byte_data)
  );

  // An empty stage drives zero so the write bus never shows stale data.
  always_comb begin
    w_wdata = {DATA_W{1'b0}};
    if (r_valid) begin
      case (r_sel)
        WDATA_SEL_WORD: w_wdata = r_mdata;
        WDATA_SEL_BYTE: w_wdata = w_byte_data;
        WDATA_SEL_UIMM: w_wdata = DATA_W'(upper_imm(r_imm));
        WDATA_SEL_ALU:  w_wdata = r_alu;
        default:        w_wdata = {DATA_W{1'b0}};
      endcase
    end else begin
      w_wdata = {DATA_W{1'b0}};
    end
  end

  assign rf_we        = w_fwd_valid & ~r_done;
  assign rf_waddr     = r_rd;
  assign rf_wdata     = w_wdata;
  assign fwd_valid    = w_fwd_valid;
  assign fwd_rd       = r_rd;
  assign fwd_data     = w_wdata;
  assign retire_count = r_retire_count;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: expected register-file writes are
// queued when an instruction is driven and popped when the write port fires.
module tb_mem_wb_writeback;

  logic        clock;
  logic        reset_n;
  logic        in_valid, in_stall, in_flush, in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wdata_sel;
  logic        in_byte_unsigned;
  logic [1:0]  in_byte_off;
  logic [31:0] in_alu_result, in_mem_rdata;
  logic [15:0] in_imm;
  logic        rf_we, fwd_valid;
  logic [4:0]  rf_waddr, fwd_rd;
  logic [31:0] rf_wdata, fwd_data;
  logic [15:0] retire_count;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count = 16'd0;

  mem_wb_writeback dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_stall         (in_stall),
    .in_flush         (in_flush),
    .in_reg_write     (in_reg_write),
    .in_rd            (in_rd),
    .in_wdata_sel     (in_wdata_sel),
    .in_byte_unsigned (in_byte_unsigned),
    .in_byte_off      (in_byte_off),
    .in_alu_result    (in_alu_result),
    .in_mem_rdata     (in_mem_rdata),
    .in_imm           (in_imm),
    .rf_we            (rf_we),
    .rf_waddr         (rf_waddr),
    .rf_wdata         (rf_wdata),
    .fwd_valid        (fwd_valid),
    .fwd_rd           (fwd_rd),
    .fwd_data         (fwd_data),
    .retire_count     (retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference write value, computed by shifting rather than by a byte case.
  function automatic logic [31:0] model_value(input logic [1:0] sel, input logic uns,
                                              input logic [1:0] off, input logic [31:0] alu,
                                              input logic [31:0] mdata, input logic [15:0] imm);
    logic [31:0] sh;
    logic [7:0]  b;
    sh = mdata >> (8 * (3 - int'(off)));
    b  = sh[7:0];
    if (sel == 2'b00) return mdata;
    if (sel == 2'b01) return uns ? {24'h000000, b} : {{24{b[7]}}, b};
    if (sel == 2'b10) return {imm, 16'h0000};
    return alu;
  endfunction

  task automatic drive_idle();
    in_valid = 1'b0; in_stall = 1'b0; in_flush = 1'b0; in_reg_write = 1'b0;
    in_rd = 5'd0; in_wdata_sel = 2'b00; in_byte_unsigned = 1'b0; in_byte_off = 2'b00;
    in_alu_result = 32'h0; in_mem_rdata = 32'h0; in_imm = 16'h0;
  endtask

  task automatic issue(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic uns, input logic [1:0] off, input logic [31:0] alu,
                       input logic [31:0] mdata, input logic [15:0] imm);
    exp_t x;
    in_valid = 1'b1; in_stall = 1'b0; in_flush = 1'b0; in_reg_write = rw;
    in_rd = rd; in_wdata_sel = sel; in_byte_unsigned = uns; in_byte_off = off;
    in_alu_result = alu; in_mem_rdata = mdata; in_imm = imm;
    if (rw && rd != 5'd0) begin
      x.rd = rd;
      x.data = model_value(sel, uns, off, alu, mdata, imm);
      sb.push_back(x);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    issue(1'b1, 5'd4, 2'b11, 1'b0, 2'b00, 32'hDEAD_BEEF, 32'h0, 16'h0);
    void'(sb.pop_back());
    cycle();
    cycle();
    checks++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_we: rf_we=%0b fwd_valid=%0b want 0/0", rf_we, fwd_valid);
    end
    checks++;
    if (retire_count !== 16'd0 || rf_wdata !== 32'h0 || rf_waddr !== 5'd0) begin
      errors++;
      $display("FAIL reset_vals: count=%0d wdata=%h waddr=%0d want 0/0/0", retire_count, rf_wdata, rf_waddr);
    end
    reset_n = 1'b1;
    drive_idle();
    cycle();
  endtask

  task automatic test_alu();
    issue(1'b1, 5'd5, 2'b11, 1'b0, 2'b00, 32'h0000_1234, 32'hFFFF_0000, 16'h5555);
    cycle();
    drive_idle();
    checks++;
    if (rf_we !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL alu_we: rf_we=%0b pending=%0d want 1", rf_we, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (rf_waddr !== e.rd || rf_wdata !== e.data || fwd_data !== e.data || fwd_rd !== e.rd) begin
        errors++;
        $display("FAIL alu_data: waddr=%0d wdata=%h fwd=%h want %0d/%h", rf_waddr, rf_wdata, fwd_data, e.rd, e.data);
      end
    end
    cycle();
    exp_count++;
    checks++;
    if (retire_count !== exp_count || rf_we !== 1'b0) begin
      errors++; $display("FAIL alu_count: count=%0d we=%0b want %0d/0", retire_count, rf_we, exp_count);
    end
  endtask

  task automatic test_byte_loads();
    logic [1:0] offs[3] = '{2'd1, 2'd1, 2'd3};
    logic       unss[3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] want[3] = '{32'hFFFF_FFF2, 32'h0000_00F2, 32'h0000_0044};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, 5'(10 + i), 2'b01, unss[i], offs[i], 32'hAAAA_AAAA, 32'h11F2_3344, 16'h0);
      cycle();
      checks++;
      if (rf_we !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL byte_we[%0d]: rf_we=%0b want 1", i, rf_we);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rf_wdata !== want[i] || rf_wdata !== e.data || rf_waddr !== e.rd) begin
          errors++;
          $display("FAIL byte_data[%0d]: wdata=%h waddr=%0d want %h/%0d", i, rf_wdata, rf_waddr, want[i], e.rd);
        end
      end
    end
    drive_idle();
    cycle();
    exp_count += 16'd3;
    checks++;
    if (retire_count !== exp_count) begin
      errors++; $display("FAIL byte_count: count=%0d want %0d", retire_count, exp_count);
    end
  endtask

  task automatic test_uimm_r0();
    issue(1'b1, 5'd7, 2'b10, 1'b0, 2'b00, 32'h1111_1111, 32'h2222_2222, 16'hABCD);
    cycle();
    checks++;
    if (rf_we !== 1'b1 || sb.size() == 0) begin
      errors++; $display("FAIL uimm_we: rf_we=%0b want 1", rf_we);
    end else begin
      e = sb.pop_front();
      checks++;
      if (rf_wdata !== 32'hABCD_0000 || rf_waddr !== 5'd7 || rf_wdata !== e.data) begin
        errors++; $display("FAIL uimm_data: wdata=%h waddr=%0d want abcd0000/7", rf_wdata, rf_waddr);
      end
    end
    issue(1'b1, 5'd0, 2'b10, 1'b0, 2'b00, 32'h1111_1111, 32'h2222_2222, 16'hABCD);
    cycle();
    drive_idle();
    checks++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
      errors++; $display("FAIL r0_we: rf_we=%0b fwd_valid=%0b want 0/0", rf_we, fwd_valid);
    end
    cycle();
    exp_count += 16'd2;
    checks++;
    if (retire_count !== exp_count) begin
      errors++; $display("FAIL r0_count: count=%0d want %0d", retire_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[2] = '{32'hCAFE_0001, 32'hCAFE_0002};
    for (int i = 0; i < 2; i++) begin
      issue(1'b1, 5'd9, 2'b11, 1'b0, 2'b00, vals[i], 32'h0, 16'h0);
      cycle();
      checks++;
      if (rf_we !== 1'b1 || sb.size() == 0) begin
        errors++; $display("FAIL b2b_we[%0d]: rf_we=%0b want 1", i, rf_we);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rf_wdata !== vals[i] || rf_waddr !== 5'd9 || e.data !== vals[i]) begin
          errors++; $display("FAIL b2b_data[%0d]: wdata=%h want %h", i, rf_wdata, vals[i]);
        end
      end
    end
    drive_idle();
    cycle();
    exp_count += 16'd2;
    checks++;
    if (retire_count !== exp_count) begin
      errors++; $display("FAIL b2b_count: count=%0d want %0d", retire_count, exp_count);
    end
  endtask

  task automatic test_stall_then_flush();
    int we_seen;
    int fv_seen;
    we_seen = 0;
    fv_seen = 0;
    issue(1'b1, 5'd3, 2'b11, 1'b0, 2'b00, 32'h55AA_0033, 32'h0, 16'h0);
    cycle();
    if (rf_we === 1'b1 && sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (rf_wdata !== e.data || rf_waddr !== e.rd) begin
        errors++; $display("FAIL stall_data: wdata=%h waddr=%0d want %h/%0d", rf_wdata, rf_waddr, e.data, e.rd);
      end
    end
    we_seen += int'(rf_we === 1'b1);
    fv_seen += int'(fwd_valid === 1'b1);
    issue(1'b1, 5'd8, 2'b11, 1'b0, 2'b00, 32'h0BAD_0BAD, 32'h0, 16'h0);
    void'(sb.pop_back());
    in_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      we_seen += int'(rf_we === 1'b1);
      fv_seen += int'(fwd_valid === 1'b1);
      checks++;
      if (fwd_rd !== 5'd3 || fwd_data !== 32'h55AA_0033) begin
        errors++; $display("FAIL stall_fwd[%0d]: rd=%0d data=%h want 3/55aa0033", i, fwd_rd, fwd_data);
      end
    end
    checks++;
    if (we_seen != 1 || fv_seen != 4) begin
      errors++; $display("FAIL stall_pulses: we cycles=%0d fwd cycles=%0d want 1/4", we_seen, fv_seen);
    end
    exp_count++;
    checks++;
    if (retire_count !== exp_count) begin
      errors++; $display("FAIL stall_count: count=%0d want %0d", retire_count, exp_count);
    end
    in_flush = 1'b1;
    cycle();
    drive_idle();
    checks++;
    if (rf_we !== 1'b0 || fwd_valid !== 1'b0 || retire_count !== exp_count) begin
      errors++;
      $display("FAIL flush_stall: we=%0b fwd_valid=%0b count=%0d want 0/0/%0d", rf_we, fwd_valid, retire_count, exp_count);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_alu();
    test_byte_loads();
    test_uimm_r0();
    test_back_to_back();
    test_stall_then_flush();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d expected writes never seen", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
